// File: rtl/music_seq.sv
// music_seq: multi-channel note sequencer.
// Each channel walks its own note ROM and produces a square wave.
// A shared prescaler/beat timebase keeps all channels beat-aligned.
// A first-order sigma-delta accumulator mixes the channels onto one pin.
module music_seq #(
    parameter int CHANNELS   = 2,
    parameter int ADDR_W     = 10,
    parameter int PERIOD_W   = 14,
    parameter int DUR_W      = 4,
    parameter int PRESCALE   = 1024,
    parameter int BEAT_TICKS = 2048
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic [3:0]                                tempo,
    output logic [CHANNELS*ADDR_W-1:0]                rom_addr,
    input  logic [CHANNELS*(PERIOD_W+DUR_W+2)-1:0]    rom_data,
    output logic [CHANNELS-1:0]                       ch_out,
    output logic                                      mix_out,
    output logic [CHANNELS-1:0]                       playing,
    output logic                                      done
);

    localparam int WORD_W = PERIOD_W + DUR_W + 2;
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BT_W   = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam int ACC_W  = $clog2(2 * CHANNELS);

    typedef enum logic [1:0] {FETCH, DECODE, PLAY, END} state_t;

    // Disabled and reset are the same idle condition.
    logic clr;
    assign clr = reset || !enable;

    logic [PRE_W-1:0] pre;
    logic [BT_W-1:0]  bt;
    logic [3:0]       sub;
    logic [3:0]       tempo_l;
    logic             tick;
    logic             beat;

    assign tick = (pre == PRE_W'(PRESCALE - 1));
    assign beat = tick && (bt == BT_W'(BEAT_TICKS - 1)) && (sub == tempo_l);

    // Global timebase; tempo is only re-sampled on a beat so a beat never shortens mid-way.
    always_ff @(posedge clk) begin
        if (clr) begin
            pre     <= '0;
            bt      <= '0;
            sub     <= '0;
            tempo_l <= tempo;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                if (bt == BT_W'(BEAT_TICKS - 1)) begin
                    bt  <= '0;
                    sub <= (sub == tempo_l) ? 4'd0 : sub + 4'd1;
                end else begin
                    bt <= bt + 1'b1;
                end
            end
            if (beat) tempo_l <= tempo;
        end
    end

    logic [CHANNELS-1:0] is_end;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t              state, state_nx;
        logic [ADDR_W-1:0]   addr, addr_nx;
        logic [PERIOD_W-1:0] per, per_nx;
        logic [DUR_W-1:0]    dur, dur_nx;
        logic [PERIOD_W-1:0] tc, tc_nx;
        logic [DUR_W-1:0]    bc, bc_nx;
        logic                tone;
        logic [WORD_W-1:0]   w;

        assign w = rom_data[c*WORD_W +: WORD_W];

        // Channel state and note registers.
        always_ff @(posedge clk) begin
            if (clr) begin
                state <= FETCH;
                addr  <= '0;
                per   <= '0;
                dur   <= '0;
                tc    <= '0;
                bc    <= '0;
            end else begin
                state <= state_nx;
                addr  <= addr_nx;
                per   <= per_nx;
                dur   <= dur_nx;
                tc    <= tc_nx;
                bc    <= bc_nx;
            end
        end

        // Next-state: fetch/decode the note word, then count ticks and beats while playing.
        always_comb begin
            state_nx = state;
            addr_nx  = addr;
            per_nx   = per;
            dur_nx   = dur;
            tc_nx    = tc;
            bc_nx    = bc;
            case (state)
                FETCH:  state_nx = DECODE;
                DECODE: begin
                    // A loop word at address 0 would spin forever, so it ends the channel.
                    if (w[WORD_W-1] || (w[WORD_W-2] && addr == '0)) begin
                        state_nx = END;
                    end else if (w[WORD_W-2]) begin
                        addr_nx  = '0;
                        state_nx = FETCH;
                    end else begin
                        per_nx   = w[0 +: PERIOD_W];
                        dur_nx   = w[PERIOD_W +: DUR_W];
                        tc_nx    = '0;
                        bc_nx    = '0;
                        state_nx = PLAY;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (per < PERIOD_W'(2) || tc == per - 1'b1) tc_nx = '0;
                        else tc_nx = tc + 1'b1;
                    end
                    if (beat) begin
                        if (bc == dur) begin
                            addr_nx  = addr + 1'b1;
                            state_nx = FETCH;
                        end else begin
                            bc_nx = bc + 1'b1;
                        end
                    end
                end
                END:     state_nx = END;
                default: state_nx = FETCH;
            endcase
        end

        // Registered square wave: low for floor(P/2) ticks, high for ceil(P/2); P<2 is a rest.
        always_ff @(posedge clk) begin
            if (clr) tone <= 1'b0;
            else     tone <= (state == PLAY) && (per >= PERIOD_W'(2)) && (tc >= (per >> 1));
        end

        assign rom_addr[c*ADDR_W +: ADDR_W] = addr;
        assign ch_out[c]  = tone;
        assign playing[c] = (state == PLAY);
        assign is_end[c]  = (state == END);
    end

    // All channels finished.
    always_ff @(posedge clk) begin
        if (clr) done <= 1'b0;
        else     done <= &is_end;
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   n;
    logic [ACC_W:0]   sum;

    // Count active channels and add to the running error.
    always_comb begin
        n = '0;
        for (int i = 0; i < CHANNELS; i++) n = n + (ACC_W+1)'(ch_out[i]);
        sum = {1'b0, acc} + n;
    end

    // Sigma-delta mixer: emit a 1 whenever the accumulated error reaches CHANNELS.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc     <= '0;
            mix_out <= 1'b0;
        end else if (sum >= (ACC_W+1)'(CHANNELS)) begin
            acc     <= ACC_W'(sum - (ACC_W+1)'(CHANNELS));
            mix_out <= 1'b1;
        end else begin
            acc     <= ACC_W'(sum);
            mix_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_music_seq.sv
// Directed testbench for music_seq with small timebase (PRESCALE=4, BEAT_TICKS=2):
// one tick every 4 cycles, one beat every 8 cycles at tempo 0.
module tb_music_seq;

    localparam int CH = 2;
    localparam int AW = 10;
    localparam int PW = 14;
    localparam int DW = 4;
    localparam int WW = PW + DW + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic [3:0]        tempo = 4'd0;
    logic [CH*AW-1:0]  rom_addr;
    logic [CH*WW-1:0]  rom_data;
    logic [CH-1:0]     ch_out;
    logic              mix_out;
    logic [CH-1:0]     playing;
    logic              done;

    logic [WW-1:0] mem0 [16];
    logic [WW-1:0] mem1 [16];
    logic [WW-1:0] rd0 = '0;
    logic [WW-1:0] rd1 = '0;

    int checks = 0;
    int passes = 0;

    music_seq #(
        .CHANNELS(CH), .ADDR_W(AW), .PERIOD_W(PW), .DUR_W(DW),
        .PRESCALE(4), .BEAT_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tempo(tempo),
        .rom_addr(rom_addr), .rom_data(rom_data), .ch_out(ch_out),
        .mix_out(mix_out), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model, one per channel.
    always @(posedge clk) begin
        rd0 <= mem0[rom_addr[3:0]];
        rd1 <= mem1[rom_addr[AW+3:AW]];
    end
    assign rom_data = {rd1, rd0};

    function automatic logic [WW-1:0] mkw(input logic e, input logic l,
                                          input logic [DW-1:0] d, input logic [PW-1:0] p);
        return {e, l, d, p};
    endfunction

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) begin
            mem0[i] = mkw(1'b1, 1'b0, 4'd0, 14'd0);
            mem1[i] = mkw(1'b1, 1'b0, 4'd0, 14'd0);
        end
    endtask

    // Leaves time #1 after the last reset edge; the next posedge is edge 1.
    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b1;
        go(3);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        go(3);
        checks++; if (rom_addr !== '0) $display("FAIL reset_addr got=%h exp=0", rom_addr); else passes++;
        checks++; if (ch_out !== 2'b00) $display("FAIL reset_ch got=%b exp=00", ch_out); else passes++;
        checks++; if (mix_out !== 1'b0) $display("FAIL reset_mix got=%b exp=0", mix_out); else passes++;
        checks++; if (playing !== 2'b00) $display("FAIL reset_play got=%b exp=00", playing); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passes++;
        reset = 1'b0; enable = 1'b0;
        go(3);
        checks++; if (rom_addr !== '0) $display("FAIL disable_addr got=%h exp=0", rom_addr); else passes++;
        checks++; if (playing !== 2'b00) $display("FAIL disable_play got=%b exp=00", playing); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL disable_done got=%b exp=0", done); else passes++;
    endtask

    // ch0 {P=4,D=2},{end}; ch1 {end}. Tone high after edges 9..16; ends on beat at edge 24.
    task automatic test_tone();
        logic [1:0] ec;
        logic       em, ep, ed;
        logic [AW-1:0] ea;
        clear_rom();
        mem0[0] = mkw(1'b0, 1'b0, 4'd2, 14'd4);
        do_reset();
        for (int k = 1; k <= 27; k++) begin
            go(1);
            ec = {1'b0, (k >= 9 && k <= 16)};
            em = (k >= 10 && k <= 17 && (k % 2) == 1);
            ep = (k >= 2 && k <= 23);
            ea = (k >= 24) ? 10'd1 : 10'd0;
            ed = (k >= 27);
            checks++; if (ch_out !== ec) $display("FAIL tone_ch k=%0d got=%b exp=%b", k, ch_out, ec); else passes++;
            checks++; if (mix_out !== em) $display("FAIL tone_mix k=%0d got=%b exp=%b", k, mix_out, em); else passes++;
            checks++; if (playing !== {1'b0, ep}) $display("FAIL tone_play k=%0d got=%b exp=%b", k, playing, {1'b0, ep}); else passes++;
            checks++; if (rom_addr[AW-1:0] !== ea) $display("FAIL tone_addr k=%0d got=%0d exp=%0d", k, rom_addr[AW-1:0], ea); else passes++;
            checks++; if (done !== ed) $display("FAIL tone_done k=%0d got=%b exp=%b", k, done, ed); else passes++;
        end
    endtask

    // Both channels play the same note: mix_out high every cycle both are high.
    task automatic test_mix_both();
        logic [1:0] ec;
        logic       em;
        clear_rom();
        mem0[0] = mkw(1'b0, 1'b0, 4'd2, 14'd4);
        mem1[0] = mkw(1'b0, 1'b0, 4'd2, 14'd4);
        do_reset();
        for (int k = 1; k <= 27; k++) begin
            go(1);
            ec = (k >= 9 && k <= 16) ? 2'b11 : 2'b00;
            em = (k >= 10 && k <= 17);
            checks++; if (ch_out !== ec) $display("FAIL mix2_ch k=%0d got=%b exp=%b", k, ch_out, ec); else passes++;
            checks++; if (mix_out !== em) $display("FAIL mix2_mix k=%0d got=%b exp=%b", k, mix_out, em); else passes++;
        end
        checks++; if (done !== 1'b1) $display("FAIL mix2_done got=%b exp=1", done); else passes++;
    endtask

    // Rest {P=0,D=2}: silent, playing for three beats, then address 1.
    task automatic test_rest();
        logic ep;
        clear_rom();
        mem0[0] = mkw(1'b0, 1'b0, 4'd2, 14'd0);
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            go(1);
            ep = (k >= 2 && k <= 23);
            checks++; if (ch_out !== 2'b00) $display("FAIL rest_ch k=%0d got=%b exp=00", k, ch_out); else passes++;
            checks++; if (playing[0] !== ep) $display("FAIL rest_play k=%0d got=%b exp=%b", k, playing[0], ep); else passes++;
            checks++; if (rom_addr[AW-1:0] !== ((k >= 24) ? 10'd1 : 10'd0))
                $display("FAIL rest_addr k=%0d got=%0d exp=%0d", k, rom_addr[AW-1:0], (k >= 24) ? 1 : 0); else passes++;
        end
    endtask

    // Loop: addresses 0,1,2,0,1,2..., loop word skipped; loop at addr 0 ends the channel.
    task automatic test_loop();
        int  ea;
        logic ep;
        clear_rom();
        mem0[0] = mkw(1'b0, 1'b0, 4'd0, 14'd6);
        mem0[1] = mkw(1'b0, 1'b0, 4'd0, 14'd10);
        mem0[2] = mkw(1'b0, 1'b1, 4'd0, 14'd0);
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            go(1);
            if (k < 8) ea = 0;
            else if (k < 16) ea = 1;
            else if (k < 18) ea = 2;
            else if (k < 24) ea = 0;
            else if (k < 32) ea = 1;
            else if (k < 34) ea = 2;
            else if (k < 40) ea = 0;
            else ea = 1;
            ep = (k >= 2 && k <= 7) || (k >= 10 && k <= 15) || (k >= 20 && k <= 23) ||
                 (k >= 26 && k <= 31) || (k >= 36 && k <= 39);
            checks++; if (rom_addr[AW-1:0] !== AW'(ea)) $display("FAIL loop_addr k=%0d got=%0d exp=%0d", k, rom_addr[AW-1:0], ea); else passes++;
            checks++; if (playing[0] !== ep) $display("FAIL loop_play k=%0d got=%b exp=%b", k, playing[0], ep); else passes++;
            checks++; if (done !== 1'b0) $display("FAIL loop_done k=%0d got=%b exp=0", k, done); else passes++;
        end
        clear_rom();
        mem0[0] = mkw(1'b0, 1'b1, 4'd0, 14'd6);
        do_reset();
        go(2);
        checks++; if (playing !== 2'b00) $display("FAIL loop0_play got=%b exp=00", playing); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL loop0_done_early got=%b exp=0", done); else passes++;
        go(1);
        checks++; if (done !== 1'b1) $display("FAIL loop0_done got=%b exp=1", done); else passes++;
        checks++; if (rom_addr[AW-1:0] !== 10'd0) $display("FAIL loop0_addr got=%0d exp=0", rom_addr[AW-1:0]); else passes++;
    endtask

    // Drop enable (or assert reset) mid-note at address 1, then restart from scratch.
    task automatic test_interrupt(input bit use_reset);
        logic ep, ec;
        logic [AW-1:0] ea;
        clear_rom();
        mem0[0] = mkw(1'b0, 1'b0, 4'd0, 14'd4);
        mem0[1] = mkw(1'b0, 1'b0, 4'd2, 14'd4);
        do_reset();
        go(12);
        checks++; if (rom_addr[AW-1:0] !== 10'd1) $display("FAIL intr_pre_addr r=%0d got=%0d exp=1", use_reset, rom_addr[AW-1:0]); else passes++;
        checks++; if (playing[0] !== 1'b1) $display("FAIL intr_pre_play r=%0d got=%b exp=1", use_reset, playing[0]); else passes++;
        if (use_reset) reset = 1'b1; else enable = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            go(1);
            checks++; if (rom_addr !== '0) $display("FAIL intr_addr r=%0d k=%0d got=%h exp=0", use_reset, k, rom_addr); else passes++;
            checks++; if (playing !== 2'b00) $display("FAIL intr_play r=%0d k=%0d got=%b exp=00", use_reset, k, playing); else passes++;
            checks++; if ({ch_out, mix_out, done} !== 4'b0) $display("FAIL intr_outs r=%0d k=%0d got=%b exp=0000", use_reset, k, {ch_out, mix_out, done}); else passes++;
        end
        reset = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            go(1);
            ea = (k >= 8) ? 10'd1 : 10'd0;
            ep = (k >= 2 && k <= 7) || (k >= 10);
            ec = (k >= 17);
            checks++; if (rom_addr[AW-1:0] !== ea) $display("FAIL restart_addr r=%0d k=%0d got=%0d exp=%0d", use_reset, k, rom_addr[AW-1:0], ea); else passes++;
            checks++; if (playing[0] !== ep) $display("FAIL restart_play r=%0d k=%0d got=%b exp=%b", use_reset, k, playing[0], ep); else passes++;
            checks++; if (ch_out[0] !== ec) $display("FAIL restart_ch r=%0d k=%0d got=%b exp=%b", use_reset, k, ch_out[0], ec); else passes++;
        end
    endtask

    // Tempo 0->3 mid-beat: beats at edges 8, 16, then every 32 cycles (48, 80).
    task automatic test_tempo();
        int ea;
        clear_rom();
        for (int i = 0; i < 12; i++) mem0[i] = mkw(1'b0, 1'b0, 4'd0, 14'd0);
        tempo = 4'd0;
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            go(1);
            if (k == 12) tempo = 4'd3;
            ea = int'(k >= 8) + int'(k >= 16) + int'(k >= 48) + int'(k >= 80);
            checks++; if (rom_addr[AW-1:0] !== AW'(ea)) $display("FAIL tempo_addr k=%0d got=%0d exp=%0d", k, rom_addr[AW-1:0], ea); else passes++;
        end
        tempo = 4'd0;
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_tone();
        test_mix_both();
        test_rest();
        test_loop();
        test_interrupt(1'b0);
        test_interrupt(1'b1);
        test_tempo();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
